// File: rtl/mmss_bcd_timer.sv
// ---------------------------------------------------------------------------
// mmss_bcd_timer
//
// Free-running BCD minute:second timer. A prescaler divides clk down to a
// one-second tick, and each tick ripples the four mm:ss digits. A small
// IDLE/RUN/PAUSE state machine is driven by start/stop/clear pulses.
// Per-second (sec_tick) and roll-over (wrap) strobes feed display and chime
// logic.
//
// Parameters:
//   CLK_DIV  clk cycles per one-second tick (>= 2)
//   PRESC_W  prescaler width, 2**PRESC_W >= CLK_DIV
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   pulse: begin / resume counting
//   stop       in   pulse: pause counting
//   clear      in   pulse: zero the digits, return to IDLE
//   nums_0_s   out  [3:0] seconds ones, 0-9
//   nums_1_s   out  [2:0] seconds tens, 0-5
//   nums_0_m   out  [3:0] minutes ones, 0-9
//   nums_1_m   out  [2:0] minutes tens, 0-5
//   running    out  high while in RUN
//   sec_tick   out  one-cycle pulse on every digit advance
//   wrap       out  one-cycle pulse on 59:59 -> 00:00
//
// Optional build macro TIMER_LOAD_EN adds a preset path:
//   load       in   pulse: copy load_* into the digits (IDLE/PAUSE only)
//   load_m1    in   [2:0] minutes tens value
//   load_m0    in   [3:0] minutes ones value
//   load_s1    in   [2:0] seconds tens value
//   load_s0    in   [3:0] seconds ones value
//   load_err   out  one-cycle pulse when a load is rejected as out of range
// ---------------------------------------------------------------------------
module mmss_bcd_timer #(
    parameter int CLK_DIV = 50000000,
    parameter int PRESC_W = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
`ifdef TIMER_LOAD_EN
    input  logic       load,
    input  logic [2:0] load_m1,
    input  logic [3:0] load_m0,
    input  logic [2:0] load_s1,
    input  logic [3:0] load_s0,
    output logic       load_err,
`endif
    output logic [3:0] nums_0_s,
    output logic [2:0] nums_1_s,
    output logic [3:0] nums_0_m,
    output logic [2:0] nums_1_m,
    output logic       running,
    output logic       sec_tick,
    output logic       wrap
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

    state_t             state_q;
    logic [PRESC_W-1:0] presc_q;
    logic [3:0]         s0_q;
    logic [2:0]         s1_q;
    logic [3:0]         m0_q;
    logic [2:0]         m1_q;
    logic               running_q;
    logic               sec_tick_q;
    logic               wrap_q;

    // Incremented digit set, used only on a tick edge.
    logic [3:0] s0_inc;
    logic [2:0] s1_inc;
    logic [3:0] m0_inc;
    logic [2:0] m1_inc;
    logic       roll_over;
    logic       tick_due;

    assign tick_due = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

    // Ripple BCD increment. The >= compares fold any stray value back to 0
    // so a digit can never stick outside its legal range.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        s0_inc    = s0_q;
        s1_inc    = s1_q;
        m0_inc    = m0_q;
        m1_inc    = m1_q;
        roll_over = 1'b0;
        if (s0_q >= 4'd9) begin
            s0_inc = 4'd0;
            if (s1_q >= 3'd5) begin
                s1_inc = 3'd0;
                if (m0_q >= 4'd9) begin
                    m0_inc = 4'd0;
                    if (m1_q >= 3'd5) begin
                        m1_inc    = 3'd0;
                        roll_over = 1'b1;
                    end else begin
                        m1_inc = m1_q + 3'd1;
                    end
                end else begin
                    m0_inc = m0_q + 4'd1;
                end
            end else begin
                s1_inc = s1_q + 3'd1;
            end
        end else begin
            s0_inc = s0_q + 4'd1;
        end
    end

`ifdef TIMER_LOAD_EN
    logic load_err_q;
    logic load_ok;
    logic load_take;

    assign load_ok   = (load_s0 <= 4'd9) && (load_s1 <= 3'd5) &&
                       (load_m0 <= 4'd9) && (load_m1 <= 3'd5);
    // A load in RUN is ignored entirely and falls through to stop/start.
    assign load_take = load && (state_q != ST_RUN);
    assign load_err  = load_err_q;
`endif

    // Single state machine: state, prescaler, digits and all registered
    // outputs. Priority is rst > clear > (load) > stop > start.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: reset is sampled on the clock edge, so it lives inside the
            // clocked branch and the sensitivity list holds only clk.
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            s0_q       <= '0;
            s1_q       <= '0;
            m0_q       <= '0;
            m1_q       <= '0;
            running_q  <= 1'b0;
            sec_tick_q <= 1'b0;
            wrap_q     <= 1'b0;
`ifdef TIMER_LOAD_EN
            load_err_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // sees the pre-edge values of the others regardless of order.
            sec_tick_q <= 1'b0;
            wrap_q     <= 1'b0;
`ifdef TIMER_LOAD_EN
            load_err_q <= 1'b0;
`endif
            if (clear) begin
                // Any tick due on this edge is dropped.
                state_q   <= ST_IDLE;
                presc_q   <= '0;
                s0_q      <= '0;
                s1_q      <= '0;
                m0_q      <= '0;
                m1_q      <= '0;
                running_q <= 1'b0;
            end
`ifdef TIMER_LOAD_EN
            else if (load_take) begin
                if (load_ok) begin
                    state_q <= ST_PAUSE;
                    presc_q <= '0;
                    s0_q    <= load_s0;
                    s1_q    <= load_s1;
                    m0_q    <= load_m0;
                    m1_q    <= load_m1;
                end else begin
                    load_err_q <= 1'b1;
                end
                running_q <= 1'b0;
            end
`endif
            else begin
                // The prescaler follows the current state, so the stop edge
                // itself still counts and PAUSE keeps the sub-second phase.
                if (state_q == ST_RUN) begin
                    if (tick_due) begin
                        presc_q    <= '0;
                        s0_q       <= s0_inc;
                        s1_q       <= s1_inc;
                        m0_q       <= m0_inc;
                        m1_q       <= m1_inc;
                        sec_tick_q <= 1'b1;
                        wrap_q     <= roll_over;
                    end else begin
                        presc_q <= presc_q + 1'b1;
                    end
                end

                unique case (state_q)
                    ST_IDLE: begin
                        if (start && !stop) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (stop) begin
                            state_q   <= ST_PAUSE;
                            running_q <= 1'b0;
                        end
                    end
                    ST_PAUSE: begin
                        if (start && !stop) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign nums_0_s = s0_q;
    assign nums_1_s = s1_q;
    assign nums_0_m = m0_q;
    assign nums_1_m = m1_q;
    assign running  = running_q;
    assign sec_tick = sec_tick_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_mmss_bcd_timer.sv
// ---------------------------------------------------------------------------
// tb_mmss_bcd_timer
//
// Directed bench for mmss_bcd_timer with CLK_DIV = 4. Inputs change 1 time
// unit after a rising edge and outputs are sampled at the same point, so each
// observation reflects the edge just taken. Digits are compared as a packed
// hex word {0,m1,m0,0,s1,s0}, i.e. 12:34 reads as 16'h1234.
// Build with TIMER_LOAD_EN defined to exercise the preset path as well.
// ---------------------------------------------------------------------------
module tb_mmss_bcd_timer;

    localparam int CLK_DIV = 4;
    localparam int PRESC_W = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       clear;
    logic [3:0] nums_0_s;
    logic [2:0] nums_1_s;
    logic [3:0] nums_0_m;
    logic [2:0] nums_1_m;
    logic       running;
    logic       sec_tick;
    logic       wrap;
`ifdef TIMER_LOAD_EN
    logic       load;
    logic [2:0] load_m1;
    logic [3:0] load_m0;
    logic [2:0] load_s1;
    logic [3:0] load_s0;
    logic       load_err;
`endif

    int checks_total  = 0;
    int checks_passed = 0;

    mmss_bcd_timer #(
        .CLK_DIV (CLK_DIV),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
`ifdef TIMER_LOAD_EN
        .load     (load),
        .load_m1  (load_m1),
        .load_m0  (load_m0),
        .load_s1  (load_s1),
        .load_s0  (load_s0),
        .load_err (load_err),
`endif
        .nums_0_s (nums_0_s),
        .nums_1_s (nums_1_s),
        .nums_0_m (nums_0_m),
        .nums_1_m (nums_1_m),
        .running  (running),
        .sec_tick (sec_tick),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] digits();
        return {1'b0, nums_1_m, nums_0_m, 1'b0, nums_1_s, nums_0_s};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick_clk(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick_clk(1);
        stop = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        tick_clk(n * CLK_DIV);
    endtask

    int ticks_seen;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
`ifdef TIMER_LOAD_EN
        load    = 1'b0;
        load_m1 = '0;
        load_m0 = '0;
        load_s1 = '0;
        load_s0 = '0;
`endif
        tick_clk(2);
        rst = 1'b0;

        // Reset state
        check("rst_digits",   digits(), 16'h0000);
        check("rst_running",  16'(running), 16'h0);
        check("rst_sec_tick", 16'(sec_tick), 16'h0);
        check("rst_wrap",     16'(wrap), 16'h0);

        // Start from IDLE: first tick exactly CLK_DIV edges after start edge
        pulse_start();
        check("start_running", 16'(running), 16'h1);
        tick_clk(CLK_DIV - 1);
        check("pre_tick1_digits", digits(), 16'h0000);
        check("pre_tick1_strobe", 16'(sec_tick), 16'h0);
        tick_clk(1);
        check("tick1_digits", digits(), 16'h0001);
        check("tick1_strobe", 16'(sec_tick), 16'h1);
        tick_clk(1);
        check("tick1_pulse_width", 16'(sec_tick), 16'h0);
        tick_clk(CLK_DIV - 1);
        check("tick2_digits", digits(), 16'h0002);
        check("tick2_strobe", 16'(sec_tick), 16'h1);

        // Seconds roll into minutes
        run_ticks(57);
        check("t59_digits", digits(), 16'h0059);
        run_ticks(1);
        check("t60_digits", digits(), 16'h0100);
        check("t60_wrap",   16'(wrap), 16'h0);

        // Full roll-over 59:59 -> 00:00
        run_ticks(3539);
        check("t3599_digits", digits(), 16'h5959);
        check("t3599_wrap",   16'(wrap), 16'h0);
        run_ticks(1);
        check("wrap_digits",   digits(), 16'h0000);
        check("wrap_strobe",   16'(wrap), 16'h1);
        check("wrap_sec_tick", 16'(sec_tick), 16'h1);
        check("wrap_running",  16'(running), 16'h1);
        tick_clk(1);
        check("wrap_pulse_width", 16'(wrap), 16'h0);

        // Pause two edges after a tick; phase is preserved across PAUSE
        pulse_stop();
        check("pause_running", 16'(running), 16'h0);
        ticks_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick_clk(1);
            if (sec_tick) ticks_seen++;
        end
        check("pause_no_ticks", 16'(ticks_seen), 16'h0);
        check("pause_frozen",   digits(), 16'h0000);
        pulse_start();
        check("resume_running", 16'(running), 16'h1);
        tick_clk(1);
        check("resume_pre_tick", digits(), 16'h0000);
        tick_clk(1);
        check("resume_tick_digits", digits(), 16'h0001);
        check("resume_tick_strobe", 16'(sec_tick), 16'h1);

        // clear + start together at 12:34, with a tick due on that edge
        run_ticks(753);
        check("t1234_digits", digits(), 16'h1234);
        tick_clk(CLK_DIV - 1);
        clear = 1'b1;
        start = 1'b1;
        tick_clk(1);
        clear = 1'b0;
        start = 1'b0;
        check("clear_digits",   digits(), 16'h0000);
        check("clear_running",  16'(running), 16'h0);
        check("clear_sec_tick", 16'(sec_tick), 16'h0);

        // stop in IDLE is ignored; restart shows the prescaler was zeroed
        pulse_stop();
        check("idle_stop_running", 16'(running), 16'h0);
        pulse_start();
        tick_clk(CLK_DIV);
        check("restart_tick", digits(), 16'h0001);

        // start + stop together in PAUSE stays in PAUSE
        pulse_stop();
        start = 1'b1;
        stop  = 1'b1;
        tick_clk(1);
        start = 1'b0;
        stop  = 1'b0;
        check("pause_start_stop_running", 16'(running), 16'h0);
        tick_clk(2 * CLK_DIV);
        check("pause_start_stop_digits", digits(), 16'h0001);

        // rst mid-operation on the edge where a tick is due
        pulse_start();
        tick_clk(CLK_DIV - 2);
        rst = 1'b1;
        tick_clk(1);
        rst = 1'b0;
        check("midrst_digits",   digits(), 16'h0000);
        check("midrst_running",  16'(running), 16'h0);
        check("midrst_sec_tick", 16'(sec_tick), 16'h0);

`ifdef TIMER_LOAD_EN
        // Enter PAUSE, then preset 59:53
        pulse_start();
        pulse_stop();
        load    = 1'b1;
        load_m1 = 3'd5;
        load_m0 = 4'd9;
        load_s1 = 3'd5;
        load_s0 = 4'd3;
        tick_clk(1);
        load = 1'b0;
        check("load_digits",  digits(), 16'h5953);
        check("load_no_err",  16'(load_err), 16'h0);
        check("load_running", 16'(running), 16'h0);

        // Out-of-range seconds digit rejects the whole load
        load    = 1'b1;
        load_m1 = 3'd1;
        load_s0 = 4'd10;
        tick_clk(1);
        load = 1'b0;
        check("bad_load_err",    16'(load_err), 16'h1);
        check("bad_load_digits", digits(), 16'h5953);
        tick_clk(1);
        check("bad_load_err_width", 16'(load_err), 16'h0);

        // Load resets the prescaler: 7 full seconds wrap to 00:00
        pulse_start();
        tick_clk(7 * CLK_DIV);
        check("load_wrap_digits", digits(), 16'h0000);
        check("load_wrap_strobe", 16'(wrap), 16'h1);

        // load in RUN is ignored without an error
        load    = 1'b1;
        load_s0 = 4'd10;
        tick_clk(1);
        load = 1'b0;
        check("run_load_no_err", 16'(load_err), 16'h0);
        check("run_load_running", 16'(running), 16'h1);
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
